// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Single-port memory arbiter in front of the unified instruction/data
//   memory. Three sources share the port: the flash programming port
//   (writes only, highest priority, active even during reset), the
//   load/store unit and instruction fetch. At most one access is granted
//   per cycle. Read data returns one cycle after the grant and is routed
//   to whichever requester issued the read. A starvation counter promotes
//   fetch above data after MAX_WAIT consecutive denied fetch cycles.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   flash_en/addr/data          flash write port
//   i_req/addr, i_gnt           fetch request and same-cycle grant
//   i_rvalid/rdata              fetch read response
//   d_req/we/addr/wdata, d_gnt  load/store request and same-cycle grant
//   d_rvalid/rdata              load response
//   mem_en/we/addr/wdata        memory command (word-aligned address)
//   mem_rdata                   memory read data, one cycle after a read
module mem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flash_en,
  input  logic [WIDTH-1:0] flash_addr,
  input  logic [WIDTH-1:0] flash_data,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic [WIDTH-1:0] i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  localparam logic [WIDTH-1:0] ADDR_MASK  = ~(WIDTH'(3));
  localparam logic [3:0]       MAX_WAIT_C = 4'(MAX_WAIT);

  owner_t     rd_owner;
  owner_t     rd_owner_nxt;
  logic [3:0] starve_cnt;
  logic [3:0] starve_cnt_nxt;
  logic       starved;

  assign starved = (starve_cnt == MAX_WAIT_C);

  // Grant selection and memory command
  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (flash_en) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = flash_addr & ADDR_MASK;
      mem_wdata = flash_data;
    end else if (!rst) begin
      // Data normally beats fetch; a starved fetch is promoted above it.
      if (i_req && (starved || !d_req)) begin
        i_gnt    = 1'b1;
        mem_en   = 1'b1;
        mem_addr = i_addr & ADDR_MASK;
      end else if (d_req) begin
        d_gnt     = 1'b1;
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr & ADDR_MASK;
        mem_wdata = d_wdata;
      end
    end
  end

  // Next read owner and starvation count
  always_comb begin
    rd_owner_nxt   = OWN_NONE;
    starve_cnt_nxt = starve_cnt;
    if (rst) begin
      rd_owner_nxt   = OWN_NONE;
      starve_cnt_nxt = 4'd0;
    end else begin
      if (i_gnt)
        rd_owner_nxt = OWN_FETCH;
      else if (d_gnt && !d_we)
        rd_owner_nxt = OWN_DATA;
      // A flash-preempted fetch is a denial like any other.
      if (!i_req || i_gnt)
        starve_cnt_nxt = 4'd0;
      else if (!starved)
        starve_cnt_nxt = starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    rd_owner   <= rd_owner_nxt;
    starve_cnt <= starve_cnt_nxt;
  end

  // Response stage: a response due in a reset cycle is dropped, so a read
  // granted just before reset rises never reports valid.
  assign i_rvalid = (rd_owner == OWN_FETCH) && !rst;
  assign d_rvalid = (rd_owner == OWN_DATA) && !rst;
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed sequence with a small behavioural
// synchronous memory and a response scoreboard queue.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flash_en;
  logic [31:0] flash_addr, flash_data;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          kind;   // 0 none, 1 fetch, 2 data
    logic [31:0] data;
  } resp_t;
  resp_t sbq[$];

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .flash_en(flash_en), .flash_addr(flash_addr), .flash_data(flash_data),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural one-cycle-latency memory
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are already applied; check this cycle, queue next-cycle response.
  task automatic step(input string tag, input bit eig, input bit edg,
                      input bit een, input bit ewe,
                      input logic [31:0] ea, input logic [31:0] ew,
                      input int kind, input logic [31:0] rd);
    resp_t r;
    resp_t n;
    int    k;
    #1;
    r = sbq.pop_front();
    k = rst ? 0 : r.kind;
    chk({tag, ".i_rvalid"}, 32'(i_rvalid), 32'(k == 1));
    chk({tag, ".d_rvalid"}, 32'(d_rvalid), 32'(k == 2));
    chk({tag, ".i_rdata"},  i_rdata, (k == 1) ? r.data : 32'h0);
    chk({tag, ".d_rdata"},  d_rdata, (k == 2) ? r.data : 32'h0);
    chk({tag, ".i_gnt"},    32'(i_gnt),  32'(eig));
    chk({tag, ".d_gnt"},    32'(d_gnt),  32'(edg));
    chk({tag, ".mem_en"},   32'(mem_en), 32'(een));
    chk({tag, ".mem_we"},   32'(mem_we), 32'(ewe));
    chk({tag, ".mem_addr"}, mem_addr, ea);
    chk({tag, ".mem_wdata"}, mem_wdata, ew);
    n.kind = kind;
    n.data = rd;
    sbq.push_back(n);
    @(negedge clk);
  endtask

  task automatic chk_starve(input string tag, input int exp);
    chk({tag, ".starve_cnt"}, 32'(dut.starve_cnt), 32'(exp));
  endtask

  initial begin
    int cnt;
    for (int a = 0; a < 64; a++) mem[a] = 32'h0;
    rst = 1'b1; flash_en = 1'b0; flash_addr = '0; flash_data = '0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0;
    sbq.push_back('{kind: 0, data: 32'h0});

    // Flash programming during reset with fetch pending
    i_req = 1'b1; i_addr = 32'h0;
    flash_en = 1'b1; flash_addr = 32'h0; flash_data = 32'h01002083;
    step("flash0", 0, 0, 1, 1, 32'h0, 32'h01002083, 0, 0);
    flash_addr = 32'h4; flash_data = 32'h00008133;
    step("flash4", 0, 0, 1, 1, 32'h4, 32'h00008133, 0, 0);
    chk_starve("rst", 0);
    flash_addr = 32'h10; flash_data = 32'hdeadbeef;
    step("flash16", 0, 0, 1, 1, 32'h10, 32'hdeadbeef, 0, 0);
    flash_addr = 32'h8; flash_data = 32'hcafef00d;
    step("flash8", 0, 0, 1, 1, 32'h8, 32'hcafef00d, 0, 0);

    // Reset with both requests and no flash: nothing granted, memory idle
    flash_en = 1'b0; d_req = 1'b1; d_addr = 32'h10;
    step("rst_idle", 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    chk_starve("rst_idle", 0);

    // Single fetch
    rst = 1'b0; d_req = 1'b0; i_req = 1'b1; i_addr = 32'h4;
    step("fetch4", 1, 0, 1, 0, 32'h4, 32'h0, 1, 32'h00008133);

    // Load vs fetch contention; fetch response from previous cycle returns
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; i_addr = 32'h8;
    step("contend", 0, 1, 1, 0, 32'h10, 32'h0, 2, 32'hdeadbeef);
    d_req = 1'b0;
    step("fetch8", 1, 0, 1, 0, 32'h8, 32'h0, 1, 32'hcafef00d);
    chk_starve("after_fetch8", 0);

    // Starvation: both held, expect 4 data grants then 1 fetch, repeating
    d_req = 1'b1; d_addr = 32'h0; i_addr = 32'h4;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      chk_starve("starve", cnt);
      if (cnt == 4) begin
        step("starve_f", 1, 0, 1, 0, 32'h4, 32'h0, 1, 32'h00008133);
        cnt = 0;
      end else begin
        step("starve_d", 0, 1, 1, 0, 32'h0, 32'h0, 2, 32'h01002083);
        cnt++;
      end
    end

    // Store to unaligned address: word-aligned, no response
    i_req = 1'b0; d_we = 1'b1; d_addr = 32'h13; d_wdata = 32'h1234;
    step("store", 0, 1, 1, 1, 32'h10, 32'h1234, 0, 0);

    // Load back the stored word
    d_we = 1'b0; d_wdata = 32'h0; d_addr = 32'h10;
    step("load10", 0, 1, 1, 0, 32'h10, 32'h0, 2, 32'h1234);

    // Flash write right after a load: response still delivered, fetch denied
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h20;
    flash_en = 1'b1; flash_addr = 32'h22; flash_data = 32'h55;
    step("flash_pre", 0, 0, 1, 1, 32'h20, 32'h55, 0, 0);
    flash_en = 1'b0;
    chk_starve("flash_denial", 1);
    step("fetch20", 1, 0, 1, 0, 32'h20, 32'h0, 1, 32'h55);

    // Reset in the cycle after a fetch grant suppresses its response
    rst = 1'b1;
    step("rst_mid", 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    rst = 1'b0; i_req = 1'b0; d_addr = 32'h1c; i_addr = 32'h8;
    chk_starve("post_rst", 0);
    step("idle", 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    step("idle2", 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
